// File: rtl/bus_responder.sv
// bus_responder: wait-state bus slave serving a RAM window (BASE..FFFE) and
// a 5-bit interrupt-enable register at FFFF.
`default_nettype none

module bus_responder #(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] BASE        = 16'hFF80
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic [15:0] A,
  input  logic [7:0]  DOUT,
  input  logic        RD,
  input  logic        WR,
  output logic [7:0]  DIN,
  output logic        READY,
  output logic        SEL,
  output logic        ERR,
  output logic [4:0]  IE
);

  localparam int RAM_BYTES = 32'hFFFF - int'(BASE);
  localparam int IDX_W     = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [15:0]      addr_q;
  logic             is_write_q;
  logic             is_ie_q;
  logic [7:0]       ram [RAM_BYTES];

  logic             hit_ram;
  logic             hit_ie;
  logic             one_strobe;
  logic             lat_strobe;
  logic             opp_strobe;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       idle_rdata;
  logic [7:0]       lat_rdata;

  assign hit_ram    = (A >= BASE) && (A != 16'hFFFF);
  assign hit_ie     = (A == 16'hFFFF);
  assign one_strobe = RD ^ WR;
  assign lat_strobe = is_write_q ? WR : RD;
  assign opp_strobe = is_write_q ? RD : WR;
  assign idx_a      = IDX_W'(A - BASE);
  assign idx_q      = IDX_W'(addr_q - BASE);

  // Read data is captured on the edge that enters ACK so it is visible during ACK.
  assign idle_rdata = hit_ie  ? {3'b111, IE} : ram[idx_a];
  assign lat_rdata  = is_ie_q ? {3'b111, IE} : ram[idx_q];

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      READY      <= 1'b1;
      SEL        <= 1'b0;
      ERR        <= 1'b0;
      DIN        <= 8'hFF;
      IE         <= 5'b00000;
      addr_q     <= 16'h0000;
      is_write_q <= 1'b0;
      is_ie_q    <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (RD && WR) begin
            ERR <= 1'b1;
          end else if (one_strobe && (hit_ram || hit_ie)) begin
            addr_q     <= A;
            is_write_q <= WR;
            is_ie_q    <= hit_ie;
            SEL        <= 1'b1;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= 3'(WAIT_STATES - 1);
              READY <= 1'b0;
            end else begin
              state <= S_ACK;
              READY <= 1'b1;
              if (RD) DIN <= idle_rdata;
            end
          end
        end
        S_WAIT: begin
          // A dropped or reversed strobe abandons the access before anything is written.
          if (!lat_strobe || opp_strobe) begin
            state <= S_IDLE;
            ERR   <= 1'b1;
            READY <= 1'b1;
            SEL   <= 1'b0;
            cnt   <= 3'd0;
          end else if (cnt == 3'd0) begin
            state <= S_ACK;
            READY <= 1'b1;
            if (!is_write_q) DIN <= lat_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_ACK: begin
          SEL <= 1'b0;
          if (is_write_q && is_ie_q) IE <= DOUT[4:0];
          state <= lat_strobe ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          if (!RD && !WR) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (state == S_ACK && is_write_q && !is_ie_q) ram[idx_q] <= DOUT;
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// tb_bus_responder: three responders (WAIT_STATES 1, 3, 0) driven from a
// vector table plus hand sequences; read data checked through a scoreboard queue.
`default_nettype none

module tb_bus_responder;

  logic        CLK;
  logic        rst_n [3];
  logic [15:0] a     [3];
  logic [7:0]  dout  [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [7:0]  din   [3];
  logic        ready [3];
  logic        sel   [3];
  logic        err   [3];
  logic [4:0]  ie    [3];

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];

  bus_responder #(.WAIT_STATES(1)) u_ws1 (
    .CLK(CLK), .nRES(rst_n[0]), .A(a[0]), .DOUT(dout[0]), .RD(rd[0]), .WR(wr[0]),
    .DIN(din[0]), .READY(ready[0]), .SEL(sel[0]), .ERR(err[0]), .IE(ie[0]));
  bus_responder #(.WAIT_STATES(3)) u_ws3 (
    .CLK(CLK), .nRES(rst_n[1]), .A(a[1]), .DOUT(dout[1]), .RD(rd[1]), .WR(wr[1]),
    .DIN(din[1]), .READY(ready[1]), .SEL(sel[1]), .ERR(err[1]), .IE(ie[1]));
  bus_responder #(.WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .nRES(rst_n[2]), .A(a[2]), .DOUT(dout[2]), .RD(rd[2]), .WR(wr[2]),
    .DIN(din[2]), .READY(ready[2]), .SEL(sel[2]), .ERR(err[2]), .IE(ie[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int ws_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete core access; caller is aligned to a falling edge.
  task automatic access(int k, logic w, logic [15:0] ad, logic [7:0] d, logic [7:0] exp_din);
    int   low;
    logic got;
    logic [7:0] e;
    a[k] = ad; dout[k] = d; rd[k] = ~w; wr[k] = w;
    if (!w) sb.push_back(exp_din);
    low = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      a[k] = 16'h0000;
      if (sel[k] && ready[k]) got = 1'b1;
      else if (!ready[k]) low++;
    end
    check("ack_seen", 32'(got), 32'd1);
    check("wait_cycles", 32'(low), 32'(ws_of(k)));
    check("ack_err", 32'(err[k]), 32'd0);
    if (!w) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("read_din", 32'(din[k]), 32'(e));
      end
    end
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(negedge CLK);
    check("post_ack_ready", 32'(ready[k]), 32'd1);
    check("post_ack_sel", 32'(sel[k]), 32'd0);
  endtask

  typedef struct packed {
    logic [1:0]  k;
    logic        w;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_din;
    logic [4:0]  exp_ie;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int acks;
    logic [7:0] e;

    tbl[0]  = '{2'd0, 1'b1, 16'hFF90, 8'h11, 8'h00, 5'h00};
    tbl[1]  = '{2'd0, 1'b1, 16'hFF80, 8'hA5, 8'h00, 5'h00};
    tbl[2]  = '{2'd0, 1'b0, 16'hFF80, 8'h00, 8'hA5, 5'h00};
    tbl[3]  = '{2'd0, 1'b1, 16'hFFFF, 8'hFF, 8'h00, 5'h1F};
    tbl[4]  = '{2'd0, 1'b0, 16'hFFFF, 8'h00, 8'hFF, 5'h1F};
    tbl[5]  = '{2'd0, 1'b1, 16'hFFFF, 8'h03, 8'h00, 5'h03};
    tbl[6]  = '{2'd0, 1'b0, 16'hFFFF, 8'h00, 8'hE3, 5'h03};
    tbl[7]  = '{2'd0, 1'b1, 16'hFFFE, 8'h3C, 8'h00, 5'h03};
    tbl[8]  = '{2'd0, 1'b0, 16'hFFFE, 8'h00, 8'h3C, 5'h03};
    tbl[9]  = '{2'd0, 1'b0, 16'hFF80, 8'h00, 8'hA5, 5'h03};
    tbl[10] = '{2'd1, 1'b1, 16'hFFA0, 8'h42, 8'h00, 5'h00};
    tbl[11] = '{2'd1, 1'b0, 16'hFFA0, 8'h00, 8'h42, 5'h00};
    tbl[12] = '{2'd2, 1'b1, 16'hFF82, 8'h6B, 8'h00, 5'h00};
    tbl[13] = '{2'd2, 1'b0, 16'hFF82, 8'h00, 8'h6B, 5'h00};

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; a[k] = 16'h0000; dout[k] = 8'h00; rd[k] = 1'b0; wr[k] = 1'b0;
    end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(ready[k]), 32'd1);
      check("rst_sel",   32'(sel[k]),   32'd0);
      check("rst_err",   32'(err[k]),   32'd0);
      check("rst_din",   32'(din[k]),   32'hFF);
      check("rst_ie",    32'(ie[k]),    32'd0);
      rst_n[k] = 1'b1;
    end

    // Unmapped read leaves the responder idle.
    a[0] = 16'hC000; rd[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("nohit_ready", 32'(ready[0]), 32'd1);
      check("nohit_sel",   32'(sel[0]),   32'd0);
      check("nohit_din",   32'(din[0]),   32'hFF);
      check("nohit_err",   32'(err[0]),   32'd0);
    end
    rd[0] = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      access(int'(tbl[i].k), tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].exp_din);
      check("vec_ie", 32'(ie[tbl[i].k]), 32'(tbl[i].exp_ie));
    end

    // RD and WR together: one ERR pulse, no write.
    a[0] = 16'hFF90; dout[0] = 8'hEE; rd[0] = 1'b1; wr[0] = 1'b1;
    @(negedge CLK);
    check("both_err",   32'(err[0]),   32'd1);
    check("both_ready", 32'(ready[0]), 32'd1);
    check("both_sel",   32'(sel[0]),   32'd0);
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(negedge CLK);
    check("both_err_clear", 32'(err[0]), 32'd0);
    access(0, 1'b0, 16'hFF90, 8'h00, 8'h11);

    // WAIT_STATES=3: write abandoned in its 2nd wait cycle.
    a[1] = 16'hFFA0; dout[1] = 8'h99; wr[1] = 1'b1;
    @(negedge CLK);
    check("drop_wait1_ready", 32'(ready[1]), 32'd0);
    @(negedge CLK);
    check("drop_wait2_ready", 32'(ready[1]), 32'd0);
    wr[1] = 1'b0;
    @(negedge CLK);
    check("drop_err",   32'(err[1]),   32'd1);
    check("drop_ready", 32'(ready[1]), 32'd1);
    check("drop_sel",   32'(sel[1]),   32'd0);
    @(negedge CLK);
    check("drop_err_clear", 32'(err[1]), 32'd0);
    access(1, 1'b0, 16'hFFA0, 8'h00, 8'h42);

    // Asynchronous reset in the middle of a pending write.
    access(1, 1'b1, 16'hFF81, 8'h33, 8'h00);
    access(1, 1'b1, 16'hFFFF, 8'h15, 8'h00);
    check("pre_rst_ie", 32'(ie[1]), 32'h15);
    a[1] = 16'hFF81; dout[1] = 8'h5A; wr[1] = 1'b1;
    @(negedge CLK);
    check("pre_rst_wait", 32'(ready[1]), 32'd0);
    #2 rst_n[1] = 1'b0;
    #1;
    check("async_rst_ready", 32'(ready[1]), 32'd1);
    check("async_rst_sel",   32'(sel[1]),   32'd0);
    check("async_rst_ie",    32'(ie[1]),    32'd0);
    check("async_rst_din",   32'(din[1]),   32'hFF);
    @(negedge CLK);
    wr[1] = 1'b0; rst_n[1] = 1'b1;
    access(1, 1'b0, 16'hFF81, 8'h00, 8'h33);

    // WAIT_STATES=0: RD held for 5 cycles gives exactly one ACK, then HOLD.
    a[2] = 16'hFF82; rd[2] = 1'b1;
    sb.push_back(8'h6B);
    acks = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (ready[2] && sel[2]) begin
        acks++;
        e = sb.pop_front();
        check("hold_read_din", 32'(din[2]), 32'(e));
      end else begin
        check("hold_ready", 32'(ready[2]), 32'd1);
        check("hold_sel",   32'(sel[2]),   32'd0);
      end
    end
    rd[2] = 1'b0;
    @(negedge CLK);
    check("hold_exit_sel", 32'(sel[2]), 32'd0);
    check("hold_ack_count", 32'(acks), 32'd1);
    access(2, 1'b0, 16'hFF82, 8'h00, 8'h6B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
